// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: requester ports plus RAM-side bus of the two-port RAM arbiter.
//   p0_*/p1_*  : req/we/addr/wdata in, gnt/rvalid out, per requester
//   rdata/busy : shared registered read data, init-sweep indicator
//   mem_*      : RAM write enable/address/write data out, async read data in
//   master     : requester + RAM side (drives requests and mem_rdata)
//   slave      : the arbiter
interface ram_port_arbiter_if #(
    parameter int ADDR_BITS = 2,
    parameter int DATA_BITS = 8
);
    logic                 p0_req, p1_req;
    logic                 p0_we, p1_we;
    logic [ADDR_BITS-1:0] p0_addr, p1_addr;
    logic [DATA_BITS-1:0] p0_wdata, p1_wdata;
    logic                 p0_gnt, p1_gnt;
    logic                 p0_rvalid, p1_rvalid;
    logic [DATA_BITS-1:0] rdata;
    logic                 busy;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [DATA_BITS-1:0] mem_wdata;
    logic [DATA_BITS-1:0] mem_rdata;

    modport master (
        output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata, mem_rdata,
        input  p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, rdata, busy, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata, mem_rdata,
        output p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, rdata, busy, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-port round-robin RAM arbiter that zero-fills the RAM after reset.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : ram_port_arbiter_if slave (requester ports, shared rdata, busy, RAM bus)
module ram_port_arbiter #(
    parameter int ADDR_BITS = 2,
    parameter int DATA_BITS = 8
) (
    input logic              clk,
    input logic              rst_n,
    ram_port_arbiter_if.slave bus
);
    typedef enum logic {INIT, RUN} state_t;

    state_t               state_q;
    logic [ADDR_BITS-1:0] cnt_q;
    logic                 last_q;
    logic                 rv0_q, rv1_q;
    logic [DATA_BITS-1:0] rdata_q;
    logic                 run, g0, g1, rd0_d, rd1_d;

    // Reset cycles behave like INIT: no grants, sweep drives the RAM bus.
    assign run = rst_n && state_q == RUN;
    // last_q = 1 means port 1 was granted last, so port 0 wins a contention.
    assign g0 = run && bus.p0_req && (!bus.p1_req || last_q);
    assign g1 = run && bus.p1_req && (!bus.p0_req || !last_q);
    assign rd0_d = g0 && !bus.p0_we;
    assign rd1_d = g1 && !bus.p1_we;

    assign bus.p0_gnt    = g0;
    assign bus.p1_gnt    = g1;
    assign bus.p0_rvalid = rv0_q;
    assign bus.p1_rvalid = rv1_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = state_q == INIT;
    assign bus.mem_we    = run ? (g0 && bus.p0_we) || (g1 && bus.p1_we) : 1'b1;
    // Idle RUN cycles park the address on port 0.
    assign bus.mem_addr  = !run ? cnt_q : g1 ? bus.p1_addr : bus.p0_addr;
    assign bus.mem_wdata = !run ? '0 : g1 ? bus.p1_wdata : bus.p0_wdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (state_q == INIT) cnt_q <= cnt_q + 1'b1;
            state_q <= (state_q == INIT && cnt_q == '1) ? RUN : state_q;
            rv0_q   <= rd0_d;
            rv1_q   <= rd1_d;
            if (g0 || g1) last_q <= g1;
            if (rd0_d || rd1_d) rdata_q <= bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed scoreboard bench for ram_port_arbiter with a behavioural RAM.
module tb_ram_port_arbiter;
    typedef struct {
        logic       port;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic fill = 1'b1;
    logic [7:0] ram [4];
    exp_t q[$];
    int checks = 0;
    int fails = 0;

    ram_port_arbiter_if #(.ADDR_BITS(2), .DATA_BITS(8)) bus ();
    ram_port_arbiter #(.ADDR_BITS(2), .DATA_BITS(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 4; i++) ram[i] <= 8'hFF;
        end else if (bus.mem_we) begin
            ram[bus.mem_addr] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = ram[bus.mem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic port, input logic [7:0] data);
        exp_t e;
        e.port = port;
        e.data = data;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (bus.p0_rvalid || bus.p1_rvalid) begin
            chk("rvalid_exclusive", {31'd0, bus.p0_rvalid && bus.p1_rvalid}, 0);
            if (q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_rvalid: got p0=%0b p1=%0b expected none", bus.p0_rvalid, bus.p1_rvalid);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rvalid_port", {31'd0, bus.p1_rvalid}, {31'd0, e.port});
                chk("rdata", {24'd0, bus.rdata}, {24'd0, e.data});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.p0_req = 1; bus.p0_we = 1; bus.p0_addr = 2; bus.p0_wdata = 8'hA5;
        bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 2; bus.p1_wdata = 8'h00;
        nxt();
        fill = 0;
        #1;
        chk("rst_gnt0", {31'd0, bus.p0_gnt}, 0);
        chk("rst_gnt1", {31'd0, bus.p1_gnt}, 0);
        chk("rst_mem_we", {31'd0, bus.mem_we}, 1);
        nxt();
        chk("rst_rdata", {24'd0, bus.rdata}, 0);
        chk("rst_rvalid", {30'd0, bus.p0_rvalid, bus.p1_rvalid}, 0);
        chk("rst_busy", {31'd0, bus.busy}, 1);
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("init_busy", {31'd0, bus.busy}, 1);
            chk("init_mem_we", {31'd0, bus.mem_we}, 1);
            chk("init_mem_addr", {30'd0, bus.mem_addr}, i);
            chk("init_mem_wdata", {24'd0, bus.mem_wdata}, 0);
            chk("init_gnt", {30'd0, bus.p0_gnt, bus.p1_gnt}, 0);
            nxt();
        end
        #1;
        chk("run_busy", {31'd0, bus.busy}, 0);
        chk("first_gnt", {30'd0, bus.p0_gnt, bus.p1_gnt}, 2);
        chk("wr_mem_addr", {30'd0, bus.mem_addr}, 2);
        chk("wr_mem_wdata", {24'd0, bus.mem_wdata}, 8'hA5);
        chk("wr_mem_we", {31'd0, bus.mem_we}, 1);
        nxt();
        bus.p0_req = 0;
        #1;
        chk("rd_gnt1", {30'd0, bus.p0_gnt, bus.p1_gnt}, 1);
        chk("rd_mem_we", {31'd0, bus.mem_we}, 0);
        push(1, 8'hA5);
        nxt();
        bus.p1_req = 0;
        bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 2;
        bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("alt_gnt", {30'd0, bus.p0_gnt, bus.p1_gnt}, (k % 2 == 0) ? 2 : 1);
            if (k % 2 == 0) push(0, 8'hA5); else push(1, 8'h00);
            nxt();
        end
        bus.p0_req = 0;
        for (int k = 0; k < 3; k++) begin
            bus.p1_addr = (k == 2) ? 2'd3 : 2'(k);
            #1;
            chk("solo_gnt1", {30'd0, bus.p0_gnt, bus.p1_gnt}, 1);
            push(1, 8'h00);
            nxt();
        end
        bus.p1_req = 0;
        bus.p0_req = 1; bus.p0_we = 1; bus.p0_addr = 1; bus.p0_wdata = 8'h3C;
        #1;
        chk("wr3c_gnt0", {30'd0, bus.p0_gnt, bus.p1_gnt}, 2);
        nxt();
        bus.p0_req = 0;
        bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 1;
        #1;
        chk("rd3c_gnt1", {30'd0, bus.p0_gnt, bus.p1_gnt}, 1);
        push(1, 8'h3C);
        nxt();
        bus.p1_req = 0;
        bus.p0_req = 1; bus.p0_we = 1; bus.p0_addr = 0; bus.p0_wdata = 8'h77;
        nxt();
        #1;
        chk("rdata_hold", {24'd0, bus.rdata}, 8'h3C);
        bus.p0_req = 0; bus.p0_addr = 3;
        #1;
        chk("idle_gnt", {30'd0, bus.p0_gnt, bus.p1_gnt}, 0);
        chk("idle_mem_we", {31'd0, bus.mem_we}, 0);
        chk("idle_mem_addr", {30'd0, bus.mem_addr}, 3);
        nxt();
        bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 2;
        rst_n = 0;
        #1;
        chk("mid_rst_gnt", {30'd0, bus.p0_gnt, bus.p1_gnt}, 0);
        chk("mid_rst_mem_we", {31'd0, bus.mem_we}, 1);
        nxt();
        rst_n = 1;
        bus.p0_req = 0;
        #1;
        chk("mid_rst_rvalid", {30'd0, bus.p0_rvalid, bus.p1_rvalid}, 0);
        chk("mid_rst_rdata", {24'd0, bus.rdata}, 0);
        for (int i = 0; i < 4; i++) begin
            chk("resweep_busy", {31'd0, bus.busy}, 1);
            chk("resweep_addr", {30'd0, bus.mem_addr}, i);
            chk("resweep_we", {31'd0, bus.mem_we}, 1);
            nxt();
            #1;
        end
        bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 2;
        bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 1;
        #1;
        chk("post_rst_gnt0", {30'd0, bus.p0_gnt, bus.p1_gnt}, 2);
        push(0, 8'h00);
        nxt();
        bus.p0_req = 0;
        #1;
        chk("post_rst_gnt1", {30'd0, bus.p0_gnt, bus.p1_gnt}, 1);
        push(1, 8'h00);
        nxt();
        bus.p1_req = 0;
        repeat (3) nxt();
        chk("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter ADDR_BITS, default 2: RAM address width; depth is 2**ADDR_BITS.
REQ-002 Parameter DATA_BITS, default 8: RAM word width.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 p0_req, p1_req  input  1 each  port request; held high until granted.
REQ-006 p0_we, p1_we  input  1 each  1 = write, 0 = read; valid while req is high.
REQ-007 p0_addr, p1_addr  input  ADDR_BITS each  access address.
REQ-008 p0_wdata, p1_wdata  input  DATA_BITS each  write data.
REQ-009 p0_gnt, p1_gnt  output  1 each  request accepted this cycle; combinational.
REQ-010 p0_rvalid, p1_rvalid  output  1 each  registered read-data strobe.
REQ-011 rdata  output  DATA_BITS  registered read data, shared by both ports.
REQ-012 busy  output  1  high while the init sweep runs.
REQ-013 mem_we  output  1  RAM write enable; combinational.
REQ-014 mem_addr  output  ADDR_BITS  RAM address; combinational.
REQ-015 mem_wdata  output  DATA_BITS  RAM write data; combinational.
REQ-016 mem_rdata  input  DATA_BITS  RAM asynchronous read data for mem_addr.

Function
REQ-017 The FSM SHALL have two states: INIT and RUN.
REQ-018 INIT: a sweep counter runs 0 to 2**ADDR_BITS-1; each cycle mem_we=1, mem_addr=counter, mem_wdata=0.
REQ-019 INIT: after the cycle with counter = 2**ADDR_BITS-1, the FSM SHALL enter RUN; INIT lasts exactly 2**ADDR_BITS cycles.
REQ-020 busy SHALL be 1 in INIT and 0 in RUN; in INIT both gnt = 0 and requests are ignored, not lost (requesters keep req high).
REQ-021 RUN: in any cycle with at least one req, exactly one gnt SHALL be high; with no req, both gnt = 0 and mem_we = 0.
REQ-022 Arbitration SHALL be round-robin on a 1-bit last-granted pointer.
  - One req only: grant that port.
  - Both req: grant the port not granted last.
  - Pointer updates only on a grant.
REQ-023 In RUN the granted port's we/addr/wdata SHALL drive mem_we/mem_addr/mem_wdata combinationally in the grant cycle; the write commits at that clock edge.
REQ-024 A granted read SHALL load rdata <= mem_rdata and pulse the granted port's rvalid for exactly one cycle, one cycle after gnt (read latency 1).
REQ-025 A granted write SHALL NOT assert rvalid; rdata SHALL hold its value when no read is granted.
REQ-026 p0_rvalid and p1_rvalid SHALL never be high in the same cycle.
REQ-027 Back-to-back grants to the same port SHALL be allowed when the other port is not requesting; throughput is one access per cycle.
REQ-028 A read to an address written in the previous cycle SHALL return the new data; same-cycle ordering follows the RAM's write-then-read at the next edge.
REQ-029 mem_addr in RUN with no grant SHALL be don't-care but stable; it SHALL drive port 0's addr.

Reset
REQ-030 While rst_n = 0 at a clock edge, the block SHALL set:
  - state = INIT, sweep counter = 0;
  - last-granted pointer = 1, so port 0 wins the first contention;
  - rdata = 0, p0_rvalid = p1_rvalid = 0.
REQ-031 Reset asserted mid-INIT or mid-RUN SHALL restart the sweep from address 0 on the first cycle after rst_n returns high; an rvalid pending for that edge SHALL be dropped.
REQ-032 gnt outputs and mem_* outputs SHALL follow the INIT definitions during reset cycles; mem_we = 1 with mem_addr = 0 is permitted.

Verification
REQ-033 Release reset with both req high, ADDR_BITS=2 -> busy=1 for 4 cycles, mem writes 0 to addresses 0..3, no gnt; on cycle 5 p0_gnt=1.
REQ-034 After INIT, p0 writes 0xA5 to addr 2, then p1 reads addr 2 -> one cycle after p1_gnt: p1_rvalid=1, rdata=0xA5, p0_rvalid=0.
REQ-035 Both ports request continuously for 6 cycles -> grants alternate p0,p1,p0,p1,p0,p1, one per cycle.
REQ-036 Only p1 requests for 3 cycles (reads addr 0,1,3 after INIT) -> three consecutive p1_gnt, three rvalids each with rdata=0x00.
REQ-037 Assert rst_n=0 for 1 cycle in RUN during a p0 read grant -> no p0_rvalid the next cycle, busy=1, sweep restarts at address 0, prior data cleared to 0.
REQ-038 p0 writes 0x3C to addr 1 at cycle N, p1 reads addr 1 at cycle N+1 -> rdata=0x3C at N+2.
